// File: rtl/smg_pkg.sv
// rtl/smg_pkg.sv - shared constants and types for the seven-segment display path
package smg_pkg;

    // Digit code that the segment driver renders as all segments off
    localparam logic [3:0] BLANK_CODE = 4'hA;

    localparam int DIGITS_DEF = 8;
    localparam int BIN_W_DEF  = 27;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Largest value representable in the given number of decimal digits
    function automatic longint unsigned max_dec(input int digits);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < digits; i++) begin
            r = r * 64'd10;
        end
        return r - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble correction cell for one BCD digit
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential binary to packed BCD converter with leading-zero blanking
module bin2bcd_seq
    import smg_pkg::*;
#(
    parameter int BIN_W    = BIN_W_DEF,
    parameter int DIGITS   = DIGITS_DEF,
    parameter int LZ_BLANK = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam longint unsigned MAX_VAL = max_dec(DIGITS);

    state_t             state, state_nxt;
    logic [BIN_W-1:0]   bin_sr, bin_sr_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               ovf_pend, ovf_pend_nxt;
    logic [ACC_W-1:0]   bcd_nxt;
    logic               ovf_nxt;
    logic               done_nxt;
    logic               busy_nxt;

    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   blanked;
    logic [DIGITS:1]    zero_above;
    logic               in_ovf;

    assign in_ovf = 64'(bin_in) > MAX_VAL;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d (acc[4*g +: 4]),
            .q (acc_adj[4*g +: 4])
        );
    end

    // zero_above[g] is set when digit g and every digit above it are zero
    assign zero_above[DIGITS] = 1'b1;
    assign blanked[3:0]       = acc[3:0];

    for (genvar g = DIGITS - 1; g >= 1; g--) begin : g_lz
        assign zero_above[g] = zero_above[g+1] & (acc[4*g +: 4] == 4'd0);
        assign blanked[4*g +: 4] = ((LZ_BLANK != 0) && zero_above[g]) ? BLANK_CODE
                                                                     : acc[4*g +: 4];
    end

    always_comb begin
        state_nxt    = state;
        bin_sr_nxt   = bin_sr;
        acc_nxt      = acc;
        cnt_nxt      = cnt;
        ovf_pend_nxt = ovf_pend;
        bcd_nxt      = bcd_out;
        ovf_nxt      = ovf;
        done_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    bin_sr_nxt   = bin_in;
                    acc_nxt      = '0;
                    cnt_nxt      = '0;
                    ovf_pend_nxt = in_ovf;
                    state_nxt    = SHIFT;
                end
            end
            SHIFT: begin
                // High digit bits shifted out on overflow are dropped; the output is overridden
                acc_nxt    = ACC_W'({acc_adj, bin_sr[BIN_W-1]});
                bin_sr_nxt = {bin_sr[BIN_W-2:0], 1'b0};
                cnt_nxt    = cnt + CNT_W'(1);
                if (cnt == CNT_W'(BIN_W - 1)) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                bcd_nxt   = ovf_pend ? {DIGITS{BLANK_CODE}} : blanked;
                ovf_nxt   = ovf_pend;
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bin_sr   <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            bcd_out  <= {DIGITS{BLANK_CODE}};
            ovf      <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            bin_sr   <= bin_sr_nxt;
            acc      <= acc_nxt;
            cnt      <= cnt_nxt;
            ovf_pend <= ovf_pend_nxt;
            bcd_out  <= bcd_nxt;
            ovf      <= ovf_nxt;
            done     <= done_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed and swept checks for bin2bcd_seq
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [26:0] bin_in;

    logic        busy, done, ovf;
    logic [31:0] bcd_out;
    logic        busy_n, done_n, ovf_n;
    logic [31:0] bcd_n;

    int n_tests = 0;
    int n_fail  = 0;
    int excl_bad = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(27), .DIGITS(8), .LZ_BLANK(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    bin2bcd_seq #(.BIN_W(27), .DIGITS(8), .LZ_BLANK(0)) dut_nolz (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy_n),
        .done    (done_n),
        .bcd_out (bcd_n),
        .ovf     (ovf_n)
    );

    always @(negedge clk) begin
        if ((done && busy) || (done_n && busy_n)) excl_bad++;
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_bcd(input int unsigned v, input bit lz);
        logic [31:0] r;
        int unsigned t;
        if (v > 32'd99_999_999) return 32'hAAAA_AAAA;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        if (lz) begin
            for (int i = 7; i >= 1; i--) begin
                if (r[4*i +: 4] != 4'd0) break;
                r[4*i +: 4] = 4'hA;
            end
        end
        return r;
    endfunction

    task automatic wait_done(output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ok  = 1'b1;
                lat = i;
                break;
            end
        end
        if (!ok) chk("done_timeout", 64'(ok), 64'd1);
    endtask

    task automatic do_conv(input int unsigned v, output int lat);
        bit ok;
        @(negedge clk);
        start  = 1'b1;
        bin_in = 27'(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        wait_done(lat, ok);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        bit ok;
        int unsigned v;
        int d0;

        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_bcd",  64'(bcd_out), 64'hAAAA_AAAA);
        chk("rst_ovf",  64'(ovf),     64'd0);
        chk("rst_busy", 64'(busy),    64'd0);
        chk("rst_done", 64'(done),    64'd0);
        chk("rst_bcd_nolz", 64'(bcd_n), 64'hAAAA_AAAA);
        rst_n = 1'b1;

        do_conv(4_154_110, lat);
        chk("lat_4154110", 64'(lat), 64'd28);
        chk("bcd_4154110", 64'(bcd_out), 64'hA415_4110);
        chk("ovf_4154110", 64'(ovf), 64'd0);
        chk("busy_at_done", 64'(busy), 64'd0);

        do_conv(0, lat);
        chk("bcd_zero_lz",   64'(bcd_out), 64'hAAAA_AAA0);
        chk("bcd_zero_nolz", 64'(bcd_n),   64'h0000_0000);

        do_conv(99_999_999, lat);
        chk("bcd_max", 64'(bcd_out), 64'h9999_9999);
        chk("ovf_max", 64'(ovf), 64'd0);

        do_conv(100_000_000, lat);
        chk("lat_ovf",      64'(lat), 64'd28);
        chk("bcd_ovf",      64'(bcd_out), 64'hAAAA_AAAA);
        chk("ovf_ovf",      64'(ovf), 64'd1);
        chk("bcd_ovf_nolz", 64'(bcd_n), 64'hAAAA_AAAA);
        chk("ovf_ovf_nolz", 64'(ovf_n), 64'd1);

        // start while busy is dropped; start in the done cycle is taken
        @(negedge clk);
        start  = 1'b1;
        bin_in = 27'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        start  = 1'b1;
        bin_in = 27'd77;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, ok);
        chk("bcd_5_ignore77", 64'(bcd_out), 64'hAAAA_AAA5);
        start  = 1'b1;
        bin_in = 27'd123;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_b2b", 64'(busy), 64'd1);
        wait_done(lat, ok);
        chk("lat_b2b", 64'(lat), 64'd28);
        chk("bcd_123", 64'(bcd_out), 64'hAAAA_A123);

        // reset in the middle of a conversion
        @(negedge clk);
        start  = 1'b1;
        bin_in = 27'd12_345;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_bcd",  64'(bcd_out), 64'hAAAA_AAAA);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_ovf",  64'(ovf), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("midrst_no_done", 64'(done_cnt), 64'(d0));
        do_conv(42, lat);
        chk("bcd_42", 64'(bcd_out), 64'hAAAA_AA42);

        for (int i = 0; i < 1000; i++) begin
            v = $urandom_range(134_217_727, 0);
            do_conv(v, lat);
            chk("rnd_lat",      64'(lat), 64'd28);
            chk("rnd_bcd",      64'(bcd_out), 64'(ref_bcd(v, 1'b1)));
            chk("rnd_ovf",      64'(ovf), 64'(v > 32'd99_999_999));
            chk("rnd_bcd_nolz", 64'(bcd_n), 64'(ref_bcd(v, 1'b0)));
        end

        chk("done_busy_excl", 64'(excl_bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
